// File: rtl/nn_downsize.sv
// Per-lane fixed-point requantizer: round-half-up then saturate, two registered stages.
// Lanes are independent; din_valid is carried alongside the data as dout_valid.
module nn_downsize #(
  parameter int PARALLEL_IN = 4,
  parameter int DIN_WIDTH   = 32,
  parameter int DOUT_WIDTH  = 16,
  parameter int DIN_POINT   = 28,
  parameter int DOUT_POINT  = 14
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PARALLEL_IN*DIN_WIDTH-1:0]  din,
  input  logic                              din_valid,
  output logic [PARALLEL_IN*DOUT_WIDTH-1:0] dout,
  output logic                              dout_valid,
  output logic [PARALLEL_IN-1:0]            dout_ovf
);

  localparam int SHIFT   = DIN_POINT - DOUT_POINT;
  localparam int QW      = DIN_WIDTH + 1 - SHIFT;
  localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [DIN_WIDTH:0]    ONE     = {{DIN_WIDTH{1'b0}}, 1'b1};
  localparam logic [DIN_WIDTH:0]    HALF    = (SHIFT > 0) ? (ONE << HALF_SH) : {(DIN_WIDTH+1){1'b0}};
  localparam logic [DOUT_WIDTH-1:0] MAX_POS = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] MAX_NEG = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  generate
    if ((DIN_POINT < DOUT_POINT) || (DIN_WIDTH - (DIN_POINT - DOUT_POINT) < DOUT_WIDTH)) begin : g_bad_params
      $error("nn_downsize: illegal point/width parameter combination");
    end
  endgenerate

  // The value fits when every bit from the MSB down to the output sign bit agrees.
  function automatic logic [DOUT_WIDTH:0] saturate(input logic [QW-1:0] q);
    logic [QW-DOUT_WIDTH:0] top;
    logic [DOUT_WIDTH:0]    res;
    top = q[QW-1:DOUT_WIDTH-1];
    if ((top == {(QW-DOUT_WIDTH+1){1'b0}}) || (top == {(QW-DOUT_WIDTH+1){1'b1}})) begin
      res = {1'b0, q[DOUT_WIDTH-1:0]};
    end else if (q[QW-1]) begin
      res = {1'b1, MAX_NEG};
    end else begin
      res = {1'b1, MAX_POS};
    end
    return res;
  endfunction

  logic [DIN_WIDTH:0]                t_s;
  logic [PARALLEL_IN-1:0][QW-1:0]    q_s;
  logic [PARALLEL_IN-1:0][QW-1:0]    q_r;
  logic                              v1_r;
  logic [DOUT_WIDTH:0]               sat_s;
  logic [PARALLEL_IN*DOUT_WIDTH-1:0] dout_s;
  logic [PARALLEL_IN-1:0]            ovf_s;
  logic [PARALLEL_IN*DOUT_WIDTH-1:0] dout_r;
  logic                              dout_valid_r;
  logic [PARALLEL_IN-1:0]            dout_ovf_r;

  // Stage 1 combinational: sign-extend by one guard bit, add half an output LSB, drop SHIFT bits.
  always_comb begin
    t_s = {(DIN_WIDTH+1){1'b0}};
    q_s = {(PARALLEL_IN*QW){1'b0}};
    for (int i = 0; i < PARALLEL_IN; i++) begin
      t_s    = {din[i*DIN_WIDTH+DIN_WIDTH-1], din[i*DIN_WIDTH +: DIN_WIDTH]} + HALF;
      q_s[i] = t_s[DIN_WIDTH:SHIFT];
    end
  end

  // Stage 1 registers: rounded lanes and valid tag, no enable on the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r  <= {(PARALLEL_IN*QW){1'b0}};
      v1_r <= 1'b0;
    end else begin
      q_r  <= q_s;
      v1_r <= din_valid;
    end
  end

  // Stage 2 combinational: clamp each rounded lane to the output range.
  always_comb begin
    sat_s  = {(DOUT_WIDTH+1){1'b0}};
    dout_s = {(PARALLEL_IN*DOUT_WIDTH){1'b0}};
    ovf_s  = {PARALLEL_IN{1'b0}};
    for (int i = 0; i < PARALLEL_IN; i++) begin
      sat_s                               = saturate(q_r[i]);
      dout_s[i*DOUT_WIDTH +: DOUT_WIDTH] = sat_s[DOUT_WIDTH-1:0];
      ovf_s[i]                            = sat_s[DOUT_WIDTH];
    end
  end

  // Stage 2 registers: drive the outputs directly from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= {(PARALLEL_IN*DOUT_WIDTH){1'b0}};
      dout_valid_r <= 1'b0;
      dout_ovf_r   <= {PARALLEL_IN{1'b0}};
    end else begin
      dout_r       <= dout_s;
      dout_valid_r <= v1_r;
      dout_ovf_r   <= ovf_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_ovf   = dout_ovf_r;

endmodule

// File: tb/tb_nn_downsize.sv
// Self-checking bench for nn_downsize: directed vector table, random streaming
// against an arithmetic reference model, and reset corner sequences.
module tb_nn_downsize;

  localparam int NL    = 4;
  localparam int SHIFT = 14;

  logic           clk;
  logic           rst_n;
  logic [127:0]   din;
  logic           din_valid;
  logic [63:0]    dout;
  logic           dout_valid;
  logic [3:0]     dout_ovf;

  int checks;
  int failures;

  typedef struct {
    logic [127:0] din;
    logic [63:0]  dout;
    logic [3:0]   ovf;
  } vec_t;

  typedef struct {
    logic [63:0] dout;
    logic [3:0]  ovf;
    logic        v;
  } exp_t;

  vec_t tbl[4];
  exp_t e1;
  exp_t e2;
  exp_t ec;

  nn_downsize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ovf   (dout_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value/2^SHIFT rounded half-up is floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp.
  function automatic exp_t model(input logic [127:0] d, input logic v);
    exp_t   r;
    longint x;
    longint q;
    r.dout = 64'd0;
    r.ovf  = 4'd0;
    r.v    = v;
    for (int i = 0; i < NL; i++) begin
      x = longint'($signed(d[i*32 +: 32]));
      q = (x + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
      if (q > 64'sd32767) begin
        r.dout[i*16 +: 16] = 16'h7FFF;
        r.ovf[i]           = 1'b1;
      end else if (q < -64'sd32768) begin
        r.dout[i*16 +: 16] = 16'h8000;
        r.ovf[i]           = 1'b1;
      end else begin
        r.dout[i*16 +: 16] = q[15:0];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_lane();
    logic signed [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      r = r >>> 3;
    end
    return r;
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    e1        = '{dout: 64'd0, ovf: 4'd0, v: 1'b0};
    e2        = e1;
    ec        = e1;

    tbl[0] = '{din: {32'hE0000000, 32'h00000000, 32'hF0000000, 32'h10000000},
               dout: {16'h8000, 16'h0000, 16'hC000, 16'h4000}, ovf: 4'b0000};
    tbl[1] = '{din: {32'hFFFFDFFF, 32'hFFFFE000, 32'h00001FFF, 32'h00002000},
               dout: {16'hFFFF, 16'h0000, 16'h0000, 16'h0001}, ovf: 4'b0000};
    tbl[2] = '{din: {32'h1FFFDFFF, 32'h80000000, 32'h7FFFFFFF, 32'h20000000},
               dout: {16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF}, ovf: 4'b0111};
    tbl[3] = '{din: {32'h00000000, 32'h0FFFE000, 32'hDFFFDFFF, 32'hDFFFE000},
               dout: {16'h0000, 16'h4000, 16'h8000, 16'h8000}, ovf: 4'b0010};

    // Reset held with live valid input: outputs must stay cleared.
    rst_n     = 1'b0;
    din_valid = 1'b1;
    din       = {32'h12345678, 32'h7FFFFFFF, 32'h80000000, 32'h10000000};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("reset_dout[%0d]", k), dout, 64'd0);
      check($sformatf("reset_valid[%0d]", k), {63'd0, dout_valid}, 64'd0);
      check($sformatf("reset_ovf[%0d]", k), {60'd0, dout_ovf}, 64'd0);
    end
    din_valid = 1'b0;
    rst_n     = 1'b1;

    // Directed table, one vector at a time.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      din       = tbl[v].din;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      @(negedge clk);
      check($sformatf("tbl%0d_dout", v), dout, tbl[v].dout);
      check($sformatf("tbl%0d_ovf", v), {60'd0, dout_ovf}, {60'd0, tbl[v].ovf});
      check($sformatf("tbl%0d_valid", v), {63'd0, dout_valid}, 64'd1);
    end

    // Random streaming: the output seen at a negedge belongs to the input driven two negedges earlier.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("stream_valid[%0d]", k), {63'd0, dout_valid}, {63'd0, e2.v});
        if (e2.v) begin
          check($sformatf("stream_dout[%0d]", k), dout, e2.dout);
          check($sformatf("stream_ovf[%0d]", k), {60'd0, dout_ovf}, {60'd0, e2.ovf});
        end
      end
      e2        = e1;
      din       = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      din_valid = 1'($urandom_range(0, 1));
      e1        = model(din, din_valid);
    end

    // Reset mid-stream with two valid vectors in flight.
    @(negedge clk);
    din       = {32'h10000000, 32'h10000000, 32'h10000000, 32'h10000000};
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din       = {32'h7FFFFFFF, 32'h80000000, 32'h20000000, 32'hF0000000};
    din_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_valid", {63'd0, dout_valid}, 64'd0);
    check("midrst_async_dout", dout, 64'd0);
    check("midrst_async_ovf", {60'd0, dout_ovf}, 64'd0);
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    rst_n     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_idle_valid[%0d]", k), {63'd0, dout_valid}, 64'd0);
    end
    @(negedge clk);
    din       = {32'hFFFFDFFF, 32'h1FFFDFFF, 32'h00002000, 32'hE0000000};
    din_valid = 1'b1;
    ec        = model(din, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    check("midrst_lat1_valid", {63'd0, dout_valid}, 64'd0);
    @(negedge clk);
    check("midrst_lat2_valid", {63'd0, dout_valid}, 64'd1);
    check("midrst_lat2_dout", dout, ec.dout);
    check("midrst_lat2_ovf", {60'd0, dout_ovf}, {60'd0, ec.ovf});
    @(negedge clk);
    check("midrst_after_valid", {63'd0, dout_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
